// File: rtl/vend_pkg.sv
// Shared state encoding, error codes and sizing helper for the vending-machine core.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2,
        ERROR    = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CREDIT   = 2'd1;
    localparam logic [1:0] ERR_STOCK    = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    // Largest of the three hold times; sizes the shared state timer.
    function automatic int hold_max(input int a, input int b, input int c);
        int ab;
        ab = (a > b) ? a : b;
        return (ab > c) ? ab : c;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Synchronises and debounces one raw push-button and emits a single-cycle
// pulse on each debounced press; releases produce nothing.
module btn_conditioner #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk50,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             pulse_r;
    logic [CNT_W-1:0] cnt_r;
    logic             differ_s;
    logic             settled_s;

    assign differ_s    = (sync2_r != level_r);
    assign settled_s   = differ_s && (cnt_r == CNT_LAST);
    assign press_pulse = pulse_r;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounced level flips after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= settled_s && sync2_r;
            if (!differ_s) begin
                cnt_r <= CNT_ZERO;
            end else if (settled_s) begin
                cnt_r   <= CNT_ZERO;
                level_r <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending-machine sequencing core: button conditioning, saturating credit,
// round-robin item arbitration and the timed dispense / done / error cycle.
module vend_controller #(
    parameter int NUM_ITEMS       = 4,
    parameter int PRICE           = 3,
    parameter int MAX_CREDIT      = 7,
    parameter int CREDIT_W        = 3,
    parameter int DEB_CYCLES      = 1000000,
    parameter int DISPENSE_CYCLES = 50000000,
    parameter int DONE_CYCLES     = 25000000,
    parameter int ERROR_CYCLES    = 25000000
) (
    input  logic                 clk50,
    input  logic                 rst_n,
    input  logic                 btn_coin,
    input  logic [NUM_ITEMS-1:0] btn_sel,
    input  logic [NUM_ITEMS-1:0] stock_empty,
    output logic [NUM_ITEMS-1:0] motor_en,
    output logic [CREDIT_W-1:0]  credit,
    output logic [1:0]           err_code,
    output logic                 led_ready,
    output logic                 led_busy,
    output logic                 led_done,
    output logic                 led_error
);

    import vend_pkg::*;

    localparam int PTR_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int HOLD_MAX = hold_max(DISPENSE_CYCLES, DONE_CYCLES, ERROR_CYCLES);
    localparam int TMR_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [TMR_W-1:0]     TMR_ZERO  = TMR_W'(1'b0);
    localparam logic [TMR_W-1:0]     TMR_ONE   = TMR_W'(1'b1);
    localparam logic [TMR_W-1:0]     TMR_DISP  = TMR_W'(DISPENSE_CYCLES - 1);
    localparam logic [TMR_W-1:0]     TMR_DONE  = TMR_W'(DONE_CYCLES - 1);
    localparam logic [TMR_W-1:0]     TMR_ERR   = TMR_W'(ERROR_CYCLES - 1);
    localparam logic [CREDIT_W-1:0]  CRED_ZERO = CREDIT_W'(1'b0);
    localparam logic [CREDIT_W-1:0]  CRED_ONE  = CREDIT_W'(1'b1);
    localparam logic [CREDIT_W-1:0]  CRED_MAX  = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0]  CRED_COST = CREDIT_W'(PRICE);
    localparam logic [NUM_ITEMS-1:0] MOTOR_OFF = NUM_ITEMS'(1'b0);
    localparam logic [NUM_ITEMS-1:0] MOTOR_LSB = NUM_ITEMS'(1'b1);
    localparam logic [PTR_W-1:0]     PTR_ZERO  = PTR_W'(1'b0);

    // Bit 0 is the coin button, bits 1..NUM_ITEMS the item selects.
    logic [NUM_ITEMS:0]   raw_s;
    logic [NUM_ITEMS:0]   pulse_s;
    logic                 coin_pulse_s;
    logic [NUM_ITEMS-1:0] sel_pulse_s;

    assign raw_s        = {btn_sel, btn_coin};
    assign coin_pulse_s = pulse_s[0];
    assign sel_pulse_s  = pulse_s[NUM_ITEMS:1];

    for (genvar i = 0; i <= NUM_ITEMS; i++) begin : g_btn
        btn_conditioner #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_btn (
            .clk50       (clk50),
            .rst_n       (rst_n),
            .btn_raw     (raw_s[i]),
            .press_pulse (pulse_s[i])
        );
    end

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CREDIT_W-1:0]  credit_r;
    logic [CREDIT_W-1:0]  credit_nxt_s;
    logic [CREDIT_W-1:0]  credit_inc_s;
    logic [1:0]           err_code_r;
    logic [1:0]           err_nxt_s;
    logic [NUM_ITEMS-1:0] motor_en_r;
    logic [NUM_ITEMS-1:0] motor_nxt_s;
    logic [PTR_W-1:0]     ptr_r;
    logic [PTR_W-1:0]     ptr_nxt_s;
    logic [TMR_W-1:0]     timer_r;
    logic [TMR_W-1:0]     timer_nxt_s;
    logic                 led_ready_r;
    logic                 led_busy_r;
    logic                 led_done_r;
    logic                 led_error_r;
    logic [PTR_W-1:0]     grant_s;
    logic                 grant_vld_s;
    logic                 hit_s;
    int                   idx_s;
    logic                 coin_ok_s;
    logic                 coin_drop_s;

    // A coin at full credit is dropped rather than wrapping the counter.
    assign coin_ok_s    = coin_pulse_s && (credit_r != CRED_MAX);
    assign coin_drop_s  = coin_pulse_s && (credit_r == CRED_MAX);
    assign credit_inc_s = coin_ok_s ? (credit_r + CRED_ONE) : credit_r;

    // Round-robin grant: first select pulse at or after the pointer, wrapping.
    always_comb begin
        grant_s     = PTR_ZERO;
        grant_vld_s = 1'b0;
        hit_s       = 1'b0;
        idx_s       = 0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
            idx_s       = (int'(ptr_r) + k) % NUM_ITEMS;
            hit_s       = !grant_vld_s && sel_pulse_s[idx_s];
            grant_s     = hit_s ? PTR_W'(idx_s) : grant_s;
            grant_vld_s = grant_vld_s || hit_s;
        end
    end

    // Next-state, credit, error and motor decisions.
    always_comb begin
        state_nxt_s  = state_r;
        credit_nxt_s = credit_inc_s;
        err_nxt_s    = err_code_r;
        motor_nxt_s  = motor_en_r;
        ptr_nxt_s    = ptr_r;
        timer_nxt_s  = timer_r;
        case (state_r)
            IDLE: begin
                motor_nxt_s = MOTOR_OFF;
                // Select outcome wins over a simultaneous coin overflow.
                if (grant_vld_s) begin
                    if (stock_empty[grant_s]) begin
                        state_nxt_s = ERROR;
                        err_nxt_s   = ERR_STOCK;
                        timer_nxt_s = TMR_ERR;
                    end else if (credit_r < CRED_COST) begin
                        state_nxt_s = ERROR;
                        err_nxt_s   = ERR_CREDIT;
                        timer_nxt_s = TMR_ERR;
                    end else begin
                        state_nxt_s  = DISPENSE;
                        credit_nxt_s = credit_inc_s - CRED_COST;
                        err_nxt_s    = ERR_NONE;
                        motor_nxt_s  = MOTOR_LSB << grant_s;
                        ptr_nxt_s    = PTR_W'((int'(grant_s) + 1) % NUM_ITEMS);
                        timer_nxt_s  = TMR_DISP;
                    end
                end else if (coin_drop_s) begin
                    state_nxt_s = ERROR;
                    err_nxt_s   = ERR_OVERFLOW;
                    timer_nxt_s = TMR_ERR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DISPENSE: begin
                if (timer_r == TMR_ZERO) begin
                    state_nxt_s = DONE;
                    motor_nxt_s = MOTOR_OFF;
                    timer_nxt_s = TMR_DONE;
                end else begin
                    timer_nxt_s = timer_r - TMR_ONE;
                end
            end
            DONE: begin
                if (timer_r == TMR_ZERO) begin
                    state_nxt_s = IDLE;
                end else begin
                    timer_nxt_s = timer_r - TMR_ONE;
                end
            end
            ERROR: begin
                if (timer_r == TMR_ZERO) begin
                    state_nxt_s = IDLE;
                end else begin
                    timer_nxt_s = timer_r - TMR_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                motor_nxt_s = MOTOR_OFF;
                timer_nxt_s = TMR_ZERO;
            end
        endcase
    end

    // State, datapath and LED registers; LEDs decode the next state so they track it.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            credit_r    <= CRED_ZERO;
            err_code_r  <= ERR_NONE;
            motor_en_r  <= MOTOR_OFF;
            ptr_r       <= PTR_ZERO;
            timer_r     <= TMR_ZERO;
            led_ready_r <= 1'b1;
            led_busy_r  <= 1'b0;
            led_done_r  <= 1'b0;
            led_error_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            credit_r    <= credit_nxt_s;
            err_code_r  <= err_nxt_s;
            motor_en_r  <= motor_nxt_s;
            ptr_r       <= ptr_nxt_s;
            timer_r     <= timer_nxt_s;
            led_ready_r <= (state_nxt_s == IDLE);
            led_busy_r  <= (state_nxt_s == DISPENSE);
            led_done_r  <= (state_nxt_s == DONE);
            led_error_r <= (state_nxt_s == ERROR);
        end
    end

    assign motor_en  = motor_en_r;
    assign credit    = credit_r;
    assign err_code  = err_code_r;
    assign led_ready = led_ready_r;
    assign led_busy  = led_busy_r;
    assign led_done  = led_done_r;
    assign led_error = led_error_r;

endmodule

// File: tb/tb_vend_controller.sv
// Directed scoreboard bench for vend_controller with short debounce and hold times.
module tb_vend_controller;

    localparam logic [3:0] L_RDY = 4'b1000;
    localparam logic [3:0] L_BSY = 4'b0100;
    localparam logic [3:0] L_DN  = 4'b0010;
    localparam logic [3:0] L_ER  = 4'b0001;

    logic       clk50;
    logic       rst_n;
    logic       btn_coin;
    logic [3:0] btn_sel;
    logic [3:0] stock_empty;
    logic [3:0] motor_en;
    logic [2:0] credit;
    logic [1:0] err_code;
    logic       led_ready;
    logic       led_busy;
    logic       led_done;
    logic       led_error;

    int vectors;
    int miscompares;

    typedef struct {
        string      tag;
        logic [12:0] val;
    } exp_t;

    exp_t exp_q[$];

    vend_controller #(
        .NUM_ITEMS       (4),
        .PRICE           (3),
        .MAX_CREDIT      (7),
        .CREDIT_W        (3),
        .DEB_CYCLES      (4),
        .DISPENSE_CYCLES (10),
        .DONE_CYCLES     (5),
        .ERROR_CYCLES    (5)
    ) dut (
        .clk50       (clk50),
        .rst_n       (rst_n),
        .btn_coin    (btn_coin),
        .btn_sel     (btn_sel),
        .stock_empty (stock_empty),
        .motor_en    (motor_en),
        .credit      (credit),
        .err_code    (err_code),
        .led_ready   (led_ready),
        .led_busy    (led_busy),
        .led_done    (led_done),
        .led_error   (led_error)
    );

    initial clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    function automatic logic [12:0] mk(input logic [3:0] m, input logic [2:0] c,
                                       input logic [1:0] e, input logic [3:0] l);
        return {m, c, e, l};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [12:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [12:0] obs;
        obs = {motor_en, credit, err_code, led_ready, led_busy, led_done, led_error};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %b, required a queued expectation", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed motor=%b credit=%0d err=%0d leds=%b, expected motor=%b credit=%0d err=%0d leds=%b",
                       e.tag, obs[12:9], obs[8:6], obs[5:4], obs[3:0],
                       e.val[12:9], e.val[8:6], e.val[5:4], e.val[3:0]);
            end
        end
    endtask

    // Coin press: pulse is consumed 7 edges after raw rise, then release settles.
    task automatic coin(input string tag, input logic [2:0] c, input logic [1:0] e);
        expect_out(tag, mk(4'b0000, c, e, L_RDY));
        btn_coin = 1'b1;
        tick(7);
        check_out();
        btn_coin = 1'b0;
        tick(6);
    endtask

    task automatic run_vend(input string tag, input logic [3:0] mask,
                            input logic [3:0] onehot, input logic [2:0] c);
        expect_out({tag, "_busy"}, mk(onehot, c, 2'd0, L_BSY));
        btn_sel = mask;
        tick(7);
        check_out();
        btn_sel = 4'b0000;
        expect_out({tag, "_busy_last"}, mk(onehot, c, 2'd0, L_BSY));
        tick(9);
        check_out();
        expect_out({tag, "_done"}, mk(4'b0000, c, 2'd0, L_DN));
        tick(1);
        check_out();
        expect_out({tag, "_done_last"}, mk(4'b0000, c, 2'd0, L_DN));
        tick(4);
        check_out();
        expect_out({tag, "_ready"}, mk(4'b0000, c, 2'd0, L_RDY));
        tick(1);
        check_out();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        btn_coin    = 1'b0;
        btn_sel     = 4'b0000;
        stock_empty = 4'b0000;

        expect_out("reset", mk(4'b0000, 3'd0, 2'd0, L_RDY));
        tick(2);
        check_out();
        rst_n = 1'b1;
        tick(1);

        // 1: glitch is filtered; a held coin lands 6 edges after the first sampled edge.
        expect_out("coin_glitch", mk(4'b0000, 3'd0, 2'd0, L_RDY));
        btn_coin = 1'b1;
        tick(2);
        btn_coin = 1'b0;
        tick(10);
        check_out();
        expect_out("coin_not_yet", mk(4'b0000, 3'd0, 2'd0, L_RDY));
        btn_coin = 1'b1;
        tick(6);
        check_out();
        expect_out("coin_credit1", mk(4'b0000, 3'd1, 2'd0, L_RDY));
        tick(1);
        check_out();
        tick(1);
        btn_coin = 1'b0;
        tick(6);

        // 2: three coins then item 2.
        coin("coin_credit2", 3'd2, 2'd0);
        coin("coin_credit3", 3'd3, 2'd0);
        run_vend("vend_item2", 4'b0100, 4'b0100, 3'd0);

        // 3: insufficient credit.
        coin("coin_c1_t3", 3'd1, 2'd0);
        coin("coin_c2_t3", 3'd2, 2'd0);
        expect_out("low_credit_err", mk(4'b0000, 3'd2, 2'd1, L_ER));
        btn_sel = 4'b0001;
        tick(7);
        check_out();
        btn_sel = 4'b0000;
        expect_out("low_credit_err_last", mk(4'b0000, 3'd2, 2'd1, L_ER));
        tick(4);
        check_out();
        expect_out("low_credit_ready", mk(4'b0000, 3'd2, 2'd1, L_RDY));
        tick(1);
        check_out();

        // 4: vend item 1 so the pointer sits at 2, then arbitrate {1,3} twice.
        coin("coin_c3_t4", 3'd3, 2'd1);
        run_vend("vend_item1", 4'b0010, 4'b0010, 3'd0);
        for (int i = 1; i <= 6; i++) begin
            coin($sformatf("coin_t4_%0d", i), 3'(i), 2'd0);
        end
        run_vend("rr_grant3", 4'b1010, 4'b1000, 3'd3);
        run_vend("rr_grant1", 4'b1010, 4'b0010, 3'd0);

        // 5a: saturate, then overflow in IDLE.
        for (int i = 1; i <= 7; i++) begin
            coin($sformatf("coin_t5_%0d", i), 3'(i), 2'd0);
        end
        expect_out("overflow_err", mk(4'b0000, 3'd7, 2'd3, L_ER));
        btn_coin = 1'b1;
        tick(7);
        check_out();
        btn_coin = 1'b0;
        expect_out("overflow_err_last", mk(4'b0000, 3'd7, 2'd3, L_ER));
        tick(4);
        check_out();
        expect_out("overflow_ready", mk(4'b0000, 3'd7, 2'd3, L_RDY));
        tick(1);
        check_out();
        tick(2);

        // 5b: out-of-stock select with a simultaneous overflowing coin.
        stock_empty = 4'b0001;
        expect_out("stock_beats_overflow", mk(4'b0000, 3'd7, 2'd2, L_ER));
        btn_sel  = 4'b0001;
        btn_coin = 1'b1;
        tick(7);
        check_out();
        btn_sel  = 4'b0000;
        btn_coin = 1'b0;
        expect_out("stock_err_last", mk(4'b0000, 3'd7, 2'd2, L_ER));
        tick(4);
        check_out();
        expect_out("stock_ready", mk(4'b0000, 3'd7, 2'd2, L_RDY));
        tick(1);
        check_out();
        tick(2);

        // 5c: vend from full credit, coin lands mid-dispense, stock change ignored.
        stock_empty = 4'b0000;
        btn_sel     = 4'b0001;
        tick(3);
        btn_coin = 1'b1;
        expect_out("vend_from_max", mk(4'b0001, 3'd4, 2'd0, L_BSY));
        tick(4);
        check_out();
        btn_sel     = 4'b0000;
        stock_empty = 4'b1111;
        expect_out("coin_in_dispense", mk(4'b0001, 3'd5, 2'd0, L_BSY));
        tick(3);
        check_out();
        btn_coin = 1'b0;
        expect_out("stock_change_ignored", mk(4'b0001, 3'd5, 2'd0, L_BSY));
        tick(2);
        check_out();

        // 6: asynchronous reset mid-dispense, observed before the next edge.
        expect_out("async_reset", mk(4'b0000, 3'd0, 2'd0, L_RDY));
        rst_n = 1'b0;
        #1;
        check_out();
        tick(1);
        rst_n       = 1'b1;
        stock_empty = 4'b0000;
        expect_out("post_reset_idle", mk(4'b0000, 3'd0, 2'd0, L_RDY));
        tick(3);
        check_out();

        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
